mem_lsu: RTL

Load/store unit for the MEM stage. It consumes the access fields of the EX/MEM pipeline register and runs each load or store as one transaction on a valid/ready data bus. While a transaction is outstanding it holds `stall_MEM` high; the hazard logic drives EX/MEM `en` from it as `en = !stall_MEM`. Loads return an aligned, sign- or zero-extended result for writeback. Integer and float loads and stores (FLW/FSW, func3 = 010) share the same path.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/mem_lsu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only come in B/H/W; loads additionally allow BU/HU.
    function automatic logic func3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the data bus: byte enables, replicated store data,
// load lane extraction with sign/zero extension, and alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] lane_word;

    // Size decode drives every lane-dependent output from one case.
    always_comb begin
        be        = 4'b0000;
        wdata     = store_data;
        load_data = 32'd0;
        misalign  = 1'b0;
        lane_word = rdata >> {addr_lo, 3'b000};
        case (func3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = func3[2] ? {24'd0, lane_word[7:0]}
                                     : {{24{lane_word[7]}}, lane_word[7:0]};
            end
            F3_H, F3_HU: begin
                be        = 4'b0011 << addr_lo;
                wdata     = {2{store_data[15:0]}};
                misalign  = addr_lo[0];
                load_data = func3[2] ? {16'd0, lane_word[15:0]}
                                     : {{16{lane_word[15]}}, lane_word[15:0]};
            end
            F3_W: begin
                be        = 4'b1111;
                wdata     = store_data;
                misalign  = |addr_lo;
                load_data = rdata;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per access,
// stalling the pipeline until the response has been taken.
//
// Handshake: a request transfers on a cycle where dbus_req_valid and
// dbus_req_ready are both high; request fields stay stable while valid is
// high and unaccepted. dbus_rsp_valid is only honoured in WAIT.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_MEM,
    input  logic              memW_en_MEM,
    input  logic [2:0]        func3_MEM,
    input  logic [31:0]       ALUout_MEM,
    input  logic [31:0]       rs2_MEM,
    output logic              stall_MEM,
    output logic [31:0]       load_data_MEM,
    output logic              lsu_fault,
    output logic              dbus_req_valid,
    input  logic              dbus_req_ready,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic              dbus_we,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_rsp_valid,
    input  logic [31:0]       dbus_rdata,
    output lsu_state_t        state_dbg
);

    lsu_state_t  state;
    logic [2:0]  func3_q;
    logic [1:0]  lane_q;
    logic        load_q;

    logic        access;
    logic        is_store;
    logic        fault;
    logic        start;
    logic        use_live;
    logic [2:0]  sel_func3;
    logic [1:0]  sel_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misalign;

    // In IDLE the aligner sees the live access; afterwards it sees the
    // captured func3/lane so load extraction does not depend on held inputs.
    assign use_live  = (state == IDLE);
    assign sel_func3 = use_live ? func3_MEM : func3_q;
    assign sel_lo    = use_live ? ALUout_MEM[1:0] : lane_q;

    lsu_align u_align (
        .func3      (sel_func3),
        .addr_lo    (sel_lo),
        .store_data (rs2_MEM),
        .rdata      (dbus_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

    // Access qualification; a store wins when both strobes are set.
    assign is_store  = memW_en_MEM;
    assign access    = load_MEM | memW_en_MEM;
    assign fault     = access & (al_misalign | func3_illegal(is_store, func3_MEM));
    assign start     = use_live & access & !fault;
    assign stall_MEM = rst & (start | (state == REQ) | (state == WAIT));
    assign lsu_fault = rst & use_live & access & fault;
    assign state_dbg = state;

    // Transaction FSM with registered bus fields and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            dbus_req_valid <= 1'b0;
            dbus_addr      <= '0;
            dbus_we        <= 1'b0;
            dbus_be        <= 4'b0000;
            dbus_wdata     <= 32'd0;
            load_data_MEM  <= 32'd0;
            func3_q        <= 3'd0;
            lane_q         <= 2'd0;
            load_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= REQ;
                        dbus_req_valid <= 1'b1;
                        dbus_addr      <= {ALUout_MEM[ADDR_W-1:2], 2'b00};
                        dbus_we        <= is_store;
                        dbus_be        <= al_be;
                        dbus_wdata     <= al_wdata;
                        func3_q        <= func3_MEM;
                        lane_q         <= ALUout_MEM[1:0];
                        load_q         <= !is_store;
                    end
                end
                REQ: begin
                    if (dbus_req_ready) begin
                        dbus_req_valid <= 1'b0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (dbus_rsp_valid) begin
                        if (load_q)
                            load_data_MEM <= al_load;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
